// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
//   state_t : FSM state encoding (UNCFG/SEARCH/PAUSE; 2'd3 is illegal)
//   len_w   : width of a length field able to hold 0..max
package seq_det_pkg;

    typedef enum logic [1:0] {
        UNCFG  = 2'd0,
        SEARCH = 2'd1,
        PAUSE  = 2'd2
    } state_t;

    function automatic int unsigned len_w(input int unsigned max);
        return $unsigned($clog2(max + 1));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one event
//   clr      : clear; clr together with inc yields a count of one
//   cnt      : current count, holds at all ones
//   sat      : cnt is all ones
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_next;

    // Next count: a clear still records a simultaneous event.
    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = inc ? W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt_next = cnt + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_next;
            sat <= (cnt_next == '1);
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Run-time configurable serial pattern detector.
//   clk, rst           : clock, asynchronous active-high reset
//   cfg_load           : capture cfg_pattern/cfg_len (highest priority)
//   cfg_pattern        : pattern, bit[len-1] received first
//   cfg_len            : pattern length, legal range 1..MAX_LEN
//   overlap            : 1 = keep history after a match, 0 = restart
//   enable             : 0 = pause detection
//   in_valid, in_bit   : serial input, accepted when in_valid && in_ready
//   cnt_clr            : clear the match counter
//   in_ready           : detector is searching
//   match              : one pulse per detected pattern (Mealy or Moore)
//   match_cnt, cnt_sat : saturating match count and its saturation flag
//   cfg_err            : last load had an illegal length
//   state_o            : current state encoding
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned MEALY   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_load,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [len_w(MAX_LEN)-1:0]  cfg_len,
    input  logic                       overlap,
    input  logic                       enable,
    input  logic                       in_valid,
    input  logic                       in_bit,
    input  logic                       cnt_clr,
    output logic                       in_ready,
    output logic                       match,
    output logic [CNT_W-1:0]           match_cnt,
    output logic                       cnt_sat,
    output logic                       cfg_err,
    output logic [1:0]                 state_o
);

    localparam int unsigned LEN_W = len_w(MAX_LEN);

    state_t             state;
    state_t             state_next;
    logic [MAX_LEN-1:0] pattern;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_next;
    logic               cfg_ok;
    logic               accept;
    logic               hit;
    logic               match_q;

    assign cfg_ok   = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign in_ready = (state == SEARCH);
    // A bit offered alongside a load is dropped.
    assign accept   = in_valid && in_ready && !cfg_load;
    assign state_o  = state;

    // Only the low len bits of history take part in the compare.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
    end

    // Shift-in, saturating fill and match decision for the offered bit.
    always_comb begin
        hist_next = {hist[MAX_LEN-2:0], in_bit};
        fill_next = (fill >= len) ? len : fill + LEN_W'(1);
        hit       = accept && (fill_next == len)
                    && (((hist_next ^ pattern) & mask) == '0);
    end

    // Next-state logic; configuration load overrides everything.
    always_comb begin
        state_next = state;
        if (cfg_load) begin
            if (!cfg_ok)     state_next = UNCFG;
            else if (enable) state_next = SEARCH;
            else             state_next = PAUSE;
        end else begin
            case (state)
                UNCFG:   state_next = UNCFG;
                SEARCH:  if (!enable) state_next = PAUSE;
                PAUSE:   if (enable)  state_next = SEARCH;
                default: state_next = UNCFG;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= UNCFG;
        else     state <= state_next;
    end

    // Configuration, history and registered match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern <= '0;
            len     <= '0;
            hist    <= '0;
            fill    <= '0;
            cfg_err <= 1'b0;
            match_q <= 1'b0;
        end else begin
            match_q <= hit;
            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                hist    <= '0;
                fill    <= '0;
                cfg_err <= !cfg_ok;
            end else if (accept) begin
                hist <= hist_next;
                fill <= (hit && !overlap) ? '0 : fill_next;
            end
        end
    end

    assign match = (MEALY != 0) ? hit : match_q;

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (cnt_clr),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: a Moore/8-bit-counter instance and a Mealy/3-bit-counter
// instance share stimulus; directed tables plus hand sequences.
module tb_seq_detector;

    typedef struct {
        logic v;
        logic b;
        logic en;
        logic ovl;
        logic exp_ready;
        logic exp_hit;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       overlap = 1'b0;
    logic       enable = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       in_ready, match, cnt_sat, cfg_err;
    logic [7:0] match_cnt;
    logic [1:0] state_o;
    logic       m_in_ready, m_match, m_cnt_sat, m_cfg_err;
    logic [2:0] m_match_cnt;
    logic [1:0] m_state_o;

    int checks = 0;
    int errors = 0;

    vec_t t1[7];
    vec_t t2[7];
    vec_t t5[8];

    always #5 clk = ~clk;

    seq_detector #(.MAX_LEN(8), .CNT_W(8), .MEALY(0)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .overlap(overlap), .enable(enable), .in_valid(in_valid),
        .in_bit(in_bit), .cnt_clr(cnt_clr), .in_ready(in_ready), .match(match),
        .match_cnt(match_cnt), .cnt_sat(cnt_sat), .cfg_err(cfg_err), .state_o(state_o)
    );

    seq_detector #(.MAX_LEN(8), .CNT_W(3), .MEALY(1)) dut_m (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .overlap(overlap), .enable(enable), .in_valid(in_valid),
        .in_bit(in_bit), .cnt_clr(cnt_clr), .in_ready(m_in_ready), .match(m_match),
        .match_cnt(m_match_cnt), .cnt_sat(m_cnt_sat), .cfg_err(m_cfg_err), .state_o(m_state_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mv(input logic v, input logic b, input logic en,
                                input logic ovl, input logic rdy, input logic hit);
        vec_t r;
        r.v = v; r.b = b; r.en = en; r.ovl = ovl; r.exp_ready = rdy; r.exp_hit = hit;
        return r;
    endfunction

    // Inputs change on the falling edge; Mealy match and ready are sampled
    // before the rising edge, the Moore match just after it.
    task automatic cyc(input vec_t t, input logic clr, input string tag);
        @(negedge clk);
        in_valid = t.v; in_bit = t.b; enable = t.en; overlap = t.ovl; cnt_clr = clr;
        #1;
        chk({tag, " ready"}, 32'(in_ready), 32'(t.exp_ready));
        chk({tag, " mealy match"}, 32'(m_match), 32'(t.exp_hit));
        @(posedge clk);
        #1;
        chk({tag, " moore match"}, 32'(match), 32'(t.exp_hit));
        in_valid = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic idle_clr();
        @(negedge clk);
        in_valid = 1'b0; cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    // Load with a bit offered in the same cycle; that bit must be dropped.
    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic en);
        @(negedge clk);
        cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; enable = en;
        in_valid = 1'b1; in_bit = 1'b1;
        @(posedge clk);
        #1;
        cfg_load = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t1[0] = mv(1, 1, 1, 1, 1, 0); t1[1] = mv(1, 0, 1, 1, 1, 0);
        t1[2] = mv(1, 1, 1, 1, 1, 0); t1[3] = mv(1, 1, 1, 1, 1, 1);
        t1[4] = mv(1, 0, 1, 1, 1, 0); t1[5] = mv(1, 1, 1, 1, 1, 0);
        t1[6] = mv(1, 1, 1, 1, 1, 1);
        t2[0] = mv(1, 1, 1, 0, 1, 0); t2[1] = mv(1, 0, 1, 0, 1, 0);
        t2[2] = mv(1, 1, 1, 0, 1, 0); t2[3] = mv(1, 1, 1, 0, 1, 1);
        t2[4] = mv(1, 0, 1, 0, 1, 0); t2[5] = mv(1, 1, 1, 0, 1, 0);
        t2[6] = mv(1, 1, 1, 0, 1, 0);
        t5[0] = mv(1, 1, 1, 1, 1, 0); t5[1] = mv(1, 0, 1, 1, 1, 0);
        t5[2] = mv(0, 0, 0, 1, 1, 0); t5[3] = mv(1, 1, 0, 1, 0, 0);
        t5[4] = mv(1, 1, 0, 1, 0, 0); t5[5] = mv(0, 0, 1, 1, 0, 0);
        t5[6] = mv(1, 1, 1, 1, 1, 0); t5[7] = mv(1, 1, 1, 1, 1, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", 32'(state_o), 0);
        chk("reset ready", 32'(in_ready), 0);
        chk("reset match", 32'(match), 0);
        chk("reset cnt", 32'(match_cnt), 0);
        chk("reset sat", 32'(cnt_sat), 0);
        chk("reset cfg_err", 32'(cfg_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: overlapping detection of 1011
        load(8'b1011, 4'd4, 1'b1);
        chk("t1 state", 32'(state_o), 1);
        chk("t1 cfg_err", 32'(cfg_err), 0);
        for (int i = 0; i < 7; i++) cyc(t1[i], 1'b0, $sformatf("t1[%0d]", i));
        chk("t1 cnt", 32'(match_cnt), 2);
        chk("t1 mealy cnt", 32'(m_match_cnt), 2);

        // 2: non-overlapping detection
        idle_clr();
        chk("t2 cleared", 32'(match_cnt), 0);
        load(8'b1011, 4'd4, 1'b1);
        for (int i = 0; i < 7; i++) cyc(t2[i], 1'b0, $sformatf("t2[%0d]", i));
        chk("t2 cnt", 32'(match_cnt), 1);
        chk("t2 fill", 32'(dut.fill), 3);

        // 3: illegal lengths
        load(8'h01, 4'd0, 1'b1);
        chk("t3 len0 err", 32'(cfg_err), 1);
        chk("t3 len0 state", 32'(state_o), 0);
        for (int i = 0; i < 5; i++) cyc(mv(1, 1, 1, 1, 0, 0), 1'b0, $sformatf("t3 bit%0d", i));
        load(8'h01, 4'd9, 1'b1);
        chk("t3 len9 err", 32'(cfg_err), 1);
        chk("t3 len9 state", 32'(state_o), 0);
        chk("t3 len9 ready", 32'(in_ready), 0);
        chk("t3 cnt kept", 32'(match_cnt), 1);
        load(8'b10, 4'd2, 1'b1);
        chk("t3 reload err", 32'(cfg_err), 0);
        chk("t3 reload state", 32'(state_o), 1);

        // 4: saturation on the 3-bit counter, back-to-back hits
        idle_clr();
        load(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cyc(mv(1, 1, 1, 1, 1, 1), 1'b0, $sformatf("t4 one%0d", i));
            chk($sformatf("t4 mcnt%0d", i), 32'(m_match_cnt), (i < 7) ? 32'(i + 1) : 32'd7);
        end
        chk("t4 sat", 32'(m_cnt_sat), 1);
        chk("t4 wide cnt", 32'(match_cnt), 9);
        chk("t4 wide sat", 32'(cnt_sat), 0);
        idle_clr();
        chk("t4 clr cnt", 32'(m_match_cnt), 0);
        chk("t4 clr sat", 32'(m_cnt_sat), 0);
        cyc(mv(1, 1, 1, 1, 1, 1), 1'b1, "t4 clr+hit");
        chk("t4 clr+hit cnt", 32'(m_match_cnt), 1);
        chk("t4 clr+hit wide", 32'(match_cnt), 1);

        // 5: pause keeps history, drops offered bits
        load(8'b1011, 4'd4, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(t5[i], 1'b0, $sformatf("t5[%0d]", i));
            if (i == 3) chk("t5 pause state", 32'(state_o), 2);
        end
        chk("t5 cnt", 32'(match_cnt), 2);

        // 6: asynchronous reset mid-operation
        load(8'b1011, 4'd4, 1'b1);
        cyc(mv(1, 1, 1, 1, 1, 0), 1'b0, "t6 b0");
        cyc(mv(1, 0, 1, 1, 1, 0), 1'b0, "t6 b1");
        cyc(mv(1, 1, 1, 1, 1, 0), 1'b0, "t6 b2");
        cyc(mv(1, 1, 1, 1, 1, 1), 1'b0, "t6 b3");
        chk("t6 cnt before", 32'(match_cnt), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6 rst state", 32'(state_o), 0);
        chk("t6 rst match", 32'(match), 0);
        chk("t6 rst cnt", 32'(match_cnt), 0);
        chk("t6 rst mcnt", 32'(m_match_cnt), 0);
        chk("t6 rst sat", 32'(cnt_sat), 0);
        chk("t6 rst err", 32'(cfg_err), 0);
        chk("t6 rst ready", 32'(in_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(mv(1, 1, 1, 1, 0, 0), 1'b0, "t6 post0");
        cyc(mv(1, 0, 1, 1, 0, 0), 1'b0, "t6 post1");
        cyc(mv(1, 1, 1, 1, 0, 0), 1'b0, "t6 post2");
        cyc(mv(1, 1, 1, 1, 0, 0), 1'b0, "t6 post3");
        chk("t6 post cnt", 32'(match_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
Name: seq_detector

Overview:
- Parametrised serial pattern-detector FSM; successor to the fixed 4-state Moore controllers in this chapter.
- Pattern and length are loaded at run time; detection runs on a valid-qualified serial bit stream.
- Supports overlapping and non-overlapping detection, Moore or Mealy match output, pause, and a saturating match counter.
- Sits between a serial front-end and a status/CSR block.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- CNT_W, 8, match counter width.
- MEALY, 0, 1 = combinational match in the accepting cycle; 0 = registered match one cycle later.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_load  in  1  load pattern/length this cycle.
- cfg_pattern  in  MAX_LEN  pattern; bit[len-1] is received first, bit[0] last.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- overlap  in  1  1 = keep history after a match; 0 = restart after a match.
- enable  in  1  0 = pause detection.
- in_valid  in  1  in_bit is valid.
- in_bit  in  1  serial data.
- cnt_clr  in  1  clear the match counter.
- in_ready  out  1  bit is accepted when in_valid && in_ready.
- match  out  1  one pulse per detected pattern.
- match_cnt  out  CNT_W  saturating match count.
- cnt_sat  out  1  match_cnt equals all ones.
- cfg_err  out  1  last load had an illegal length.
- state_o  out  2  current state encoding.

Behaviour:
Reset (asynchronous, active-high, applies at any time, including mid-pattern):
- state = UNCFG; pattern = 0; len = 0; hist = 0; fill = 0.
- match = 0, match_cnt = 0, cnt_sat = 0, cfg_err = 0.

States: UNCFG = 0, SEARCH = 1, PAUSE = 2. Encoding 3 is illegal and recovers to UNCFG.
- in_ready = (state == SEARCH). Any bit offered while in_ready = 0 is dropped, with no effect.

cfg_load (accepted in any state, highest priority):
- Captures pattern and length, and clears hist and fill.
- If cfg_len == 0 or cfg_len > MAX_LEN: cfg_err <= 1, next state = UNCFG.
- Otherwise: cfg_err <= 0, next state = SEARCH if enable = 1, else PAUSE.
- A bit offered in the same cycle as cfg_load is dropped.
- match_cnt is not affected by cfg_load.

Transitions:
- SEARCH -> PAUSE when enable = 0.
- PAUSE -> SEARCH when enable = 1.
- hist and fill are retained across PAUSE.

Accepted bit:
- hist <= {hist[MAX_LEN-2:0], in_bit}.
- fill <= min(fill + 1, len).
- hit = (fill_next == len) && (hist_next[len-1:0] == pattern[len-1:0]); compare only the low len bits.
- On hit with overlap = 1: history is kept.
- On hit with overlap = 0: fill <= 0.
- overlap is sampled in the accepting cycle.

match output:
- MEALY = 1: match = hit in the same cycle, combinational.
- MEALY = 0: match is registered, high exactly the cycle after the accepting edge.
- Back-to-back hits (pattern length 1, or an overlap case) give consecutive high cycles.

Counter:
- Increments on hit and holds at 2^CNT_W - 1. cnt_sat = (match_cnt == max).
- cnt_clr alone: count becomes 0.
- cnt_clr together with hit: count becomes 1.

Decomposition:
- Shared package seq_det_pkg:
  - state_t enum {UNCFG, SEARCH, PAUSE}, 2-bit.
  - Function len_w(max) returning $clog2(max + 1).
- Sub-module sat_counter (parameter W; inputs inc and clr; outputs cnt and sat).
  - The clr+inc = 1 rule lives in sat_counter.
- The FSM, history register and compare logic stay in seq_detector.

Test Plan:
1. Overlap on. MAX_LEN = 8, MEALY = 0. Load pattern 4'b1011, len = 4, overlap = 1. Stream 1,0,1,1,0,1,1 on consecutive cycles.
   -> match high the cycle after bits 4 and 7; match_cnt = 2.
2. Overlap off. Same load and stream with overlap = 0.
   -> single match after bit 4; match_cnt = 1; fill = 3 at the end.
3. Illegal length. Load cfg_len = 0, then cfg_len = 9.
   -> cfg_err = 1, state_o = UNCFG, in_ready = 0; 5 offered bits cause no match.
   -> A legal reload (len = 2) clears cfg_err and sets state_o = SEARCH.
4. Saturation. CNT_W = 3, pattern 1'b1, len = 1, feed 9 ones.
   -> match_cnt stops at 7 with cnt_sat = 1.
   -> cnt_clr gives 0; cnt_clr together with a hit gives 1.
5. Pause. Feed 1,0, then enable = 0 while offering 1,1 (ignored, in_ready = 0), then enable = 1 and feed 1,1.
   -> exactly one match, on the last bit.
   -> With MEALY = 1, match is high in that same cycle.
6. Reset mid-operation. Assert rst mid-pattern between clock edges.
   -> All outputs go to reset values immediately (before the next edge); state_o = UNCFG.
   -> Bits after release produce no match until a reload.
